// File: rtl/counter_multi.sv
// Multi-channel quadrature encoder counter: per-channel synchroniser, run-length
// noise filter and x4/x1 decoder, with a coherent snapshot read byte-wise over a tri-state bus.
module counter_multi #(
    parameter int CHANNELS = 4,
    parameter int SIZE     = 16,
    parameter int BUS      = 8,
    parameter int FILTER   = 3,
    localparam int BYTES   = SIZE / BUS,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int BSEL_W  = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] q,
    input  logic [CHANNELS-1:0]   mode,
    input  logic                  latch,
    input  logic                  err_clr,
    input  logic                  oe,
    input  logic [SEL_W-1:0]      sel,
    input  logic [BSEL_W-1:0]     bsel,
    output logic [BUS-1:0]        data,
    output logic [CHANNELS-1:0]   err
);

    localparam logic [3:0] FILT_N = 4'(FILTER);
    localparam int SEL_N  = 2 ** SEL_W;
    localparam int BSEL_N = 2 ** BSEL_W;

    // Forward Gray successor of an {A,B} state.
    function automatic logic [1:0] gray_fwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    logic [SIZE-1:0] snap_all [CHANNELS];
    logic [BUS-1:0]  byte_tab [SEL_N][BSEL_N];

    genvar gi, gb;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [1:0]      sync1_q, sync1_d;
            logic [1:0]      sync2_q, sync2_d;
            logic [1:0]      cand_q, cand_d;
            logic [1:0]      filt_q, filt_d;
            logic [1:0]      prev_q, prev_d;
            logic [3:0]      fcnt_q, fcnt_d;
            logic [3:0]      run_len;
            logic [SIZE-1:0] cnt_q, cnt_d;
            logic [SIZE-1:0] snap_q, snap_d;
            logic            err_q, err_d;
            logic            step_fwd, step_bwd, illegal;

            // The filtered state moves only after FILTER identical samples that differ from it.
            always_comb begin
                sync1_d = q[2*gi +: 2];
                sync2_d = sync1_q;
                cand_d  = cand_q;
                fcnt_d  = fcnt_q;
                filt_d  = filt_q;
                run_len = 4'd1;
                if (sync2_q == filt_q) begin
                    fcnt_d = '0;
                end else begin
                    if (fcnt_q != '0 && sync2_q == cand_q) begin
                        run_len = fcnt_q + 4'd1;
                    end
                    cand_d = sync2_q;
                    if (run_len >= FILT_N) begin
                        filt_d = sync2_q;
                        fcnt_d = '0;
                    end else begin
                        fcnt_d = run_len;
                    end
                end
            end

            always_comb begin
                prev_d   = filt_q;
                step_fwd = (filt_q == gray_fwd(prev_q));
                step_bwd = (prev_q == gray_fwd(filt_q));
                illegal  = ((prev_q ^ filt_q) == 2'b11);
                cnt_d    = cnt_q;
                if (mode[gi]) begin
                    if (step_fwd) begin
                        cnt_d = cnt_q + SIZE'(1);
                    end else if (step_bwd) begin
                        cnt_d = cnt_q - SIZE'(1);
                    end
                end else begin
                    // x1 counts only across the 10/00 boundary so jitter there nets zero.
                    if (prev_q == 2'b10 && filt_q == 2'b00) begin
                        cnt_d = cnt_q + SIZE'(1);
                    end else if (prev_q == 2'b00 && filt_q == 2'b10) begin
                        cnt_d = cnt_q - SIZE'(1);
                    end
                end
                err_d  = illegal ? 1'b1 : (err_clr ? 1'b0 : err_q);
                snap_d = latch ? cnt_q : snap_q;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_q <= '0;
                    sync2_q <= '0;
                    cand_q  <= '0;
                    filt_q  <= '0;
                    prev_q  <= '0;
                    fcnt_q  <= '0;
                    cnt_q   <= '0;
                    snap_q  <= '0;
                    err_q   <= 1'b0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    cand_q  <= cand_d;
                    filt_q  <= filt_d;
                    prev_q  <= prev_d;
                    fcnt_q  <= fcnt_d;
                    cnt_q   <= cnt_d;
                    snap_q  <= snap_d;
                    err_q   <= err_d;
                end
            end

            assign snap_all[gi] = snap_q;
            assign err[gi]      = err_q;
        end

        // Select space is padded to a power of two; unmapped entries read as zero.
        for (gi = 0; gi < SEL_N; gi++) begin : g_sel
            for (gb = 0; gb < BSEL_N; gb++) begin : g_byte
                if (gi < CHANNELS && gb < BYTES) begin : g_map
                    assign byte_tab[gi][gb] = snap_all[gi][gb*BUS +: BUS];
                end else begin : g_pad
                    assign byte_tab[gi][gb] = '0;
                end
            end
        end
    endgenerate

    assign data = oe ? byte_tab[sel][bsel] : {BUS{1'bz}};

endmodule

// File: tb/tb_counter_multi.sv
// Scoreboard bench for counter_multi (4 channels, 16-bit counters, 8-bit bus, filter depth 3).
module tb_counter_multi;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] q;
    logic [3:0] mode;
    logic       latch;
    logic       err_clr;
    logic       oe;
    logic [1:0] sel;
    logic [0:0] bsel;
    tri1  [7:0] data;
    logic [3:0] err;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt [4];
    int          pos [4];
    logic [1:0]  seq [4];

    counter_multi #(
        .CHANNELS(4),
        .SIZE    (16),
        .BUS     (8),
        .FILTER  (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .q      (q),
        .mode   (mode),
        .latch  (latch),
        .err_clr(err_clr),
        .oe     (oe),
        .sel    (sel),
        .bsel   (bsel),
        .data   (data),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end else begin
            $display("ok   %s: got %h", tag, got);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [15:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 16'(sb_q.size()), 16'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch();
        latch = 1'b1;
        hold(1);
        latch = 1'b0;
    endtask

    task automatic read_val(input int ch, input logic [15:0] v, input string tag);
        for (int b = 0; b < 2; b++) begin
            oe   = 1'b1;
            sel  = 2'(ch);
            bsel = 1'(b);
            sb_push($sformatf("%s_b%0d", tag, b), {8'h00, v[8*b +: 8]});
            #1;
            sb_pop({8'h00, data});
        end
    endtask

    task automatic read_cnt(input int ch, input string tag);
        read_val(ch, exp_cnt[ch], tag);
    endtask

    task automatic check_err(input logic [3:0] v, input string tag);
        sb_push(tag, {12'h000, v});
        #1;
        sb_pop({12'h000, err});
    endtask

    // One Gray step on a channel, held long enough to pass the filter and decoder.
    task automatic step(input int ch, input bit fwd);
        int np;
        np = fwd ? (pos[ch] + 1) % 4 : (pos[ch] + 3) % 4;
        if (mode[ch]) begin
            exp_cnt[ch] = fwd ? exp_cnt[ch] + 16'd1 : exp_cnt[ch] - 16'd1;
        end else if (fwd && pos[ch] == 3 && np == 0) begin
            exp_cnt[ch] = exp_cnt[ch] + 16'd1;
        end else if (!fwd && pos[ch] == 0 && np == 3) begin
            exp_cnt[ch] = exp_cnt[ch] - 16'd1;
        end
        pos[ch] = np;
        q[2*ch +: 2] = seq[np];
        hold(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached limit 200000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        seq[0] = 2'b00;
        seq[1] = 2'b01;
        seq[2] = 2'b11;
        seq[3] = 2'b10;
        rst     = 1'b0;
        q       = '0;
        mode    = 4'b1101;
        latch   = 1'b0;
        err_clr = 1'b0;
        oe      = 1'b0;
        sel     = '0;
        bsel    = '0;
        for (int i = 0; i < 4; i++) begin
            exp_cnt[i] = '0;
            pos[i]     = 0;
        end
        hold(3);
        rst = 1'b1;
        hold(2);

        read_cnt(0, "rst_ch0");
        read_cnt(3, "rst_ch3");
        check_err(4'b0000, "rst_err");

        // ch0 full mode: four forward steps
        for (int i = 0; i < 4; i++) step(0, 1'b1);
        do_latch();
        read_cnt(0, "t1_ch0_fwd4");

        // ch1 div4: 8 forward, 12 backward (wrap), then mode toggle keeps count
        for (int i = 0; i < 8; i++) step(1, 1'b1);
        do_latch();
        read_cnt(1, "t2_ch1_fwd8");
        for (int i = 0; i < 12; i++) step(1, 1'b0);
        do_latch();
        read_cnt(1, "t2_ch1_wrap");
        mode[1] = 1'b1;
        hold(2);
        do_latch();
        read_cnt(1, "t2_ch1_toggle");
        step(1, 1'b1);
        do_latch();
        read_cnt(1, "t2_ch1_wrap_up");
        mode[1] = 1'b0;

        // ch0 glitch rejection and latency
        q[1:0] = 2'b01;
        hold(2);
        q[1:0] = 2'b00;
        hold(8);
        do_latch();
        read_val(0, 16'd4, "t3_pulse2");
        q[1:0] = 2'b01;
        hold(3);
        q[1:0] = 2'b00;
        hold(2);
        do_latch();
        read_val(0, 16'd4, "t3_edge6_pre");
        do_latch();
        read_val(0, 16'd5, "t3_edge6_post");
        hold(8);
        do_latch();
        read_val(0, 16'd4, "t3_return");

        // ch2 illegal steps and error flag handling
        q[5:4] = 2'b11;
        hold(8);
        check_err(4'b0100, "t4_err_set");
        do_latch();
        read_cnt(2, "t4_ch2_nocount");
        hold(4);
        check_err(4'b0100, "t4_err_sticky");
        err_clr = 1'b1;
        hold(1);
        err_clr = 1'b0;
        check_err(4'b0000, "t4_err_clr");
        q[5:4] = 2'b00;
        hold(5);
        check_err(4'b0000, "t4_err_pre");
        err_clr = 1'b1;
        hold(1);
        err_clr = 1'b0;
        check_err(4'b0100, "t4_err_wins");

        // ch3 snapshot coherence and bus behaviour
        for (int i = 0; i < 3; i++) step(3, 1'b1);
        do_latch();
        for (int i = 0; i < 5; i++) step(3, 1'b1);
        read_val(3, 16'd3, "t5_ch3_snap");
        read_cnt(0, "t5_ch0_snap");
        oe   = 1'b0;
        sel  = 2'd0;
        bsel = 1'b0;
        sb_push("t5_hiz", 16'h00FF);
        #1;
        sb_pop({8'h00, data});
        do_latch();
        read_cnt(3, "t5_ch3_new");

        // asynchronous reset between edges during motion
        q[7:6] = 2'b01;
        hold(2);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        q[7:6] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_cnt[i] = '0;
            pos[i]     = 0;
        end
        check_err(4'b0000, "t6_err_async");
        read_cnt(3, "t6_snap_async");
        @(negedge clk);
        rst = 1'b1;
        hold(2);
        do_latch();
        read_cnt(3, "t6_ch3_cnt");
        read_cnt(0, "t6_ch0_cnt");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
